lsm_sequencer: RTL and testbench
================================

// Module: lsm_sequencer
// PURPOSE
//  Sequences LDM/STM block transfers through the register-bank wrapper: walks the
//  IR register list lowest-first, drives REG_COUNTER/LSM_RD_MUX/LATCH_REG per beat,
//  handshakes each beat with memory, then issues optional base write-back.
//  Sits between the main control FSM and the register-bank wrapper.
// PARAMETERS
//  NREGS      16   register-list width (IR[15:0]); fixed at 16 for ARMv4
//  CNT_W      5    width of beat/popcount counters (holds 0..16)
// PORTS
//  clk           in   1   clock; all state updates on posedge
//  rst           in   1   synchronous active-high reset
//  start         in   1   1-cycle pulse from control FSM: LDM/STM decoded, IR valid
//  ir            in   32  instruction; [15:0] reg list, [20] L, [21] W
//  mem_ready     in   1   memory accepts/returns current beat this cycle
//  busy          out  1   high from cycle after start until DONE exits
//  xfer_valid    out  1   beat request to memory (state XFER)
//  xfer_load     out  1   1=load beat (IR[20] captured at start)
//  reg_counter   out  4   register index of current beat -> REG_COUNTER
//  lsm_rd_mux    out  1   selects REG_COUNTER as Rd -> LSM_RD_MUX
//  latch_reg     out  1   load-beat register write strobe -> LATCH_REG
//  write_back    out  1   base write-back strobe -> WRITE_BACK (state WB)
//  beat_index    out  5   0-based ordinal of current beat (address offset = 4*index)
//  reg_count     out  5   popcount of captured list, valid while busy
//  pc_loaded     out  1   1-cycle pulse in DONE if load list contained R15
//  done          out  1   1-cycle completion pulse
// BEHAVIOUR
//  - Reset: state=IDLE, mask=0, beat_index=0, reg_count=0; all outputs 0.
//  - Reset mid-transfer aborts immediately: no further beats, no write_back/done.
//  - States: IDLE, XFER, WB, DONE.
//  - IDLE: on start capture mask=ir[15:0], load=ir[20], wb=ir[21], reg_count=popcnt.
//      mask!=0 -> XFER; mask==0 -> DONE (no beats, no write_back).
//  - start while not IDLE is ignored (no recapture, no queuing).
//  - XFER: xfer_valid=1, lsm_rd_mux=1, reg_counter=lowest set bit of mask.
//      mem_ready=0: hold all outputs stable (no timeout).
//      mem_ready=1: beat completes; latch_reg=xfer_load&mem_ready (same cycle,
//      combinational); clear that mask bit; beat_index++ at clock edge.
//      Last bit cleared -> WB if wb else DONE.
//  - Store beats: latch_reg stays 0; wrapper reads Rd data via REG_COUNTER.
//  - WB: 1 cycle; write_back=1, lsm_rd_mux=0, xfer_valid=0 -> DONE.
//  - DONE: 1 cycle; done=1; pc_loaded=load & captured bit15 -> IDLE.
//  - Throughput: one beat per cycle with mem_ready held high;
//      N-reg transfer = N beats + WB(if W) + DONE.
//  - busy=1 in XFER/WB/DONE; start accepted again the cycle after DONE.
//  - beat_index saturation impossible: max 16 beats fit CNT_W=5.
//  - reg_counter stays monotonically ascending within a transfer.
// STRUCTURE
//  - Shared package/header: state encodings (LSM_IDLE/XFER/WB/DONE); IR bit positions
//    (IR_L_BIT=20, IR_W_BIT=21, IR_LIST_MSB=15).
//  - Sub-module lsm_prio_enc: 16-bit mask -> 4-bit lowest-set index + any flag
//    (combinational, reused for popcount-free next-reg selection).
//  - Popcount and FSM stay in lsm_sequencer.
// TESTING
//  1 LDM list 16'h8005, W=1, mem_ready=1: reg_counter 0,2,15; latch_reg x3;
//    write_back 1 cycle; pc_loaded=1 with done.
//  2 STM list 16'h00F0, W=0: regs 4,5,6,7; latch_reg never 1; no WB; done 5th cyc.
//  3 Backpressure: list 16'h0003, mem_ready low 3 cycles on beat 0:
//    reg_counter=0 held, beat_index=0 held, then 0->1 sequence.
//  4 Empty list 16'h0000, W=1: no xfer_valid, no write_back, done 1 cycle after start.
//  5 Reset during beat 2 of list 16'hFFFF: next cycle all outputs 0, state IDLE;
//    later start (16'h0001) runs cleanly.
//  6 start re-pulsed mid-transfer with different IR: ignored; original list completes.
//    Full list 16'hFFFF: reg_count=16, beat_index reaches 15, 16 beats.

Source files
------------

// File: rtl/lsm_pkg.sv
// Shared encodings for the LDM/STM sequencer: FSM state codes and IR field positions.
package lsm_pkg;

   localparam logic [1:0] LSM_IDLE = 2'd0;
   localparam logic [1:0] LSM_XFER = 2'd1;
   localparam logic [1:0] LSM_WB   = 2'd2;
   localparam logic [1:0] LSM_DONE = 2'd3;

   localparam int IR_L_BIT    = 20;
   localparam int IR_W_BIT    = 21;
   localparam int IR_LIST_MSB = 15;

endpackage

// File: rtl/lsm_prio_enc.sv
// Lowest-set-bit priority encoder: yields the index of the lowest set mask bit plus an any-set flag.
module lsm_prio_enc #(
   parameter int NREGS = 16
) (
   input  logic [NREGS-1:0]         mask,
   output logic [$clog2(NREGS)-1:0] idx,
   output logic                     any
);

   localparam int IDX_W = $clog2(NREGS);

   // Scan from the top down so the lowest set bit is the last one written.
   always_comb begin
      idx = '0;
      any = |mask;
      for (int i = NREGS - 1; i >= 0; i--) begin
         if (mask[i]) idx = i[IDX_W-1:0];
      end
   end

endmodule

// File: rtl/lsm_sequencer.sv
// LDM/STM block-transfer sequencer: walks the IR register list lowest-first, one beat per
// memory handshake, then an optional base write-back and a one-cycle completion pulse.
module lsm_sequencer
   import lsm_pkg::*;
#(
   parameter int NREGS = 16,
   parameter int CNT_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [31:0]      ir,
   input  logic             mem_ready,
   output logic             busy,
   output logic             xfer_valid,
   output logic             xfer_load,
   output logic [3:0]       reg_counter,
   output logic             lsm_rd_mux,
   output logic             latch_reg,
   output logic             write_back,
   output logic [CNT_W-1:0] beat_index,
   output logic [CNT_W-1:0] reg_count,
   output logic             pc_loaded,
   output logic             done
);

   logic [1:0]       state_q;
   logic [NREGS-1:0] mask_q;
   logic             load_q;
   logic             wb_q;
   logic             pc_bit_q;
   logic [CNT_W-1:0] beat_q;
   logic [CNT_W-1:0] count_q;

   logic [3:0]       enc_idx;
   logic             enc_any;
   logic [NREGS-1:0] list;
   logic [NREGS-1:0] mask_clr;
   logic             in_xfer;
   logic             unused_ir;

   function automatic logic [CNT_W-1:0] popcount(input logic [NREGS-1:0] v);
      logic [CNT_W-1:0] n;
      n = '0;
      for (int i = 0; i < NREGS; i++) begin
         n = n + CNT_W'(v[i]);
      end
      return n;
   endfunction

   assign list      = ir[IR_LIST_MSB:0];
   assign unused_ir = ^{ir[31:IR_W_BIT+1], ir[IR_L_BIT-1:IR_LIST_MSB+1]};

   // x & (x-1) drops exactly the lowest set bit, i.e. the register just transferred.
   assign mask_clr = mask_q & (mask_q - NREGS'(1));

   lsm_prio_enc #(
      .NREGS (NREGS)
   ) u_prio_enc (
      .mask (mask_q),
      .idx  (enc_idx),
      .any  (enc_any)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= LSM_IDLE;
         mask_q   <= '0;
         load_q   <= 1'b0;
         wb_q     <= 1'b0;
         pc_bit_q <= 1'b0;
         beat_q   <= '0;
         count_q  <= '0;
      end else begin
         case (state_q)
            LSM_IDLE: begin
               if (start) begin
                  mask_q   <= list;
                  load_q   <= ir[IR_L_BIT];
                  wb_q     <= ir[IR_W_BIT];
                  pc_bit_q <= ir[IR_LIST_MSB];
                  count_q  <= popcount(list);
                  beat_q   <= '0;
                  // An empty list skips both beats and write-back.
                  state_q  <= (list != '0) ? LSM_XFER : LSM_DONE;
               end
            end
            LSM_XFER: begin
               if (mem_ready) begin
                  mask_q <= mask_clr;
                  beat_q <= beat_q + CNT_W'(1);
                  if (mask_clr == '0) state_q <= wb_q ? LSM_WB : LSM_DONE;
               end
            end
            LSM_WB:   state_q <= LSM_DONE;
            LSM_DONE: state_q <= LSM_IDLE;
            default:  state_q <= LSM_IDLE;
         endcase
      end
   end

   assign in_xfer     = (state_q == LSM_XFER) && enc_any;
   assign busy        = (state_q != LSM_IDLE);
   assign xfer_valid  = in_xfer;
   assign xfer_load   = in_xfer && load_q;
   assign reg_counter = in_xfer ? enc_idx : 4'd0;
   assign lsm_rd_mux  = in_xfer;
   assign latch_reg   = in_xfer && load_q && mem_ready;
   assign write_back  = (state_q == LSM_WB);
   assign beat_index  = beat_q;
   assign reg_count   = count_q;
   assign done        = (state_q == LSM_DONE);
   assign pc_loaded   = (state_q == LSM_DONE) && load_q && pc_bit_q;

endmodule

// File: tb/tb_lsm_sequencer.sv
// Scoreboard bench for lsm_sequencer: stimulus queues expected beat/WB/DONE events, a monitor checks them.
module tb_lsm_sequencer;

   localparam int EV_BEAT = 0;
   localparam int EV_WB   = 1;
   localparam int EV_DONE = 2;

   typedef struct {
      int kind;
      int rc;
      int bi;
      int lr;
      int pc;
   } ev_t;

   logic        clk;
   logic        rst;
   logic        start;
   logic [31:0] ir;
   logic        mem_ready;
   logic        busy;
   logic        xfer_valid;
   logic        xfer_load;
   logic [3:0]  reg_counter;
   logic        lsm_rd_mux;
   logic        latch_reg;
   logic        write_back;
   logic [4:0]  beat_index;
   logic [4:0]  reg_count;
   logic        pc_loaded;
   logic        done;

   ev_t sb[$];
   int  n_tests = 0;
   int  n_fail  = 0;

   lsm_sequencer dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .ir          (ir),
      .mem_ready   (mem_ready),
      .busy        (busy),
      .xfer_valid  (xfer_valid),
      .xfer_load   (xfer_load),
      .reg_counter (reg_counter),
      .lsm_rd_mux  (lsm_rd_mux),
      .latch_reg   (latch_reg),
      .write_back  (write_back),
      .beat_index  (beat_index),
      .reg_count   (reg_count),
      .pc_loaded   (pc_loaded),
      .done        (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_idle(input string tag);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_xfer_valid"}, xfer_valid, 0);
      chk({tag, "_xfer_load"}, xfer_load, 0);
      chk({tag, "_reg_counter"}, reg_counter, 0);
      chk({tag, "_lsm_rd_mux"}, lsm_rd_mux, 0);
      chk({tag, "_latch_reg"}, latch_reg, 0);
      chk({tag, "_write_back"}, write_back, 0);
      chk({tag, "_beat_index"}, beat_index, 0);
      chk({tag, "_reg_count"}, reg_count, 0);
      chk({tag, "_pc_loaded"}, pc_loaded, 0);
      chk({tag, "_done"}, done, 0);
   endtask

   // Queue the expected events, pulse start for one cycle, return just after the accepting edge.
   task automatic launch(input logic [15:0] list, input logic l, input logic w, input int exp_cnt);
      ev_t e;
      int  k;
      k = 0;
      for (int i = 0; i < 16; i++) begin
         if (list[i]) begin
            e.kind = EV_BEAT; e.rc = i; e.bi = k; e.lr = int'(l); e.pc = 0;
            sb.push_back(e);
            k++;
         end
      end
      if (list != 16'h0000 && w) begin
         e.kind = EV_WB; e.rc = 0; e.bi = 0; e.lr = 0; e.pc = 0;
         sb.push_back(e);
      end
      e.kind = EV_DONE; e.rc = 0; e.bi = 0; e.lr = 0; e.pc = int'(l & list[15]);
      sb.push_back(e);
      ir        = 32'hE000_0000;
      ir[15:0]  = list;
      ir[20]    = l;
      ir[21]    = w;
      start     = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      chk("reg_count", reg_count, exp_cnt);
      chk("busy_after_start", busy, 1);
   endtask

   task automatic wait_done(input string name, input int exp_cycles);
      int n;
      n = 0;
      while (!done && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk({name, "_latency"}, n, exp_cycles);
      @(posedge clk);
      #1;
      chk({name, "_busy_after_done"}, busy, 0);
      chk({name, "_done_width"}, done, 0);
      chk({name, "_sb_empty"}, sb.size(), 0);
   endtask

   always @(negedge clk) begin
      ev_t e;
      if (!rst) begin
         if (xfer_valid) begin
            if (sb.size() == 0) chk("beat_unexpected", 1, 0);
            else begin
               e = sb[0];
               chk("beat_kind", e.kind, EV_BEAT);
               chk("reg_counter", reg_counter, e.rc);
               chk("beat_index", beat_index, e.bi);
               chk("latch_reg", latch_reg, e.lr & int'(mem_ready));
               chk("xfer_load", xfer_load, e.lr);
               chk("lsm_rd_mux", lsm_rd_mux, 1);
               if (mem_ready) void'(sb.pop_front());
            end
         end
         if (write_back) begin
            if (sb.size() == 0) chk("wb_unexpected", 1, 0);
            else begin
               e = sb.pop_front();
               chk("wb_kind", e.kind, EV_WB);
               chk("wb_rd_mux", lsm_rd_mux, 0);
               chk("wb_xfer_valid", xfer_valid, 0);
            end
         end
         if (done) begin
            if (sb.size() == 0) chk("done_unexpected", 1, 0);
            else begin
               e = sb.pop_front();
               chk("done_kind", e.kind, EV_DONE);
               chk("pc_loaded", pc_loaded, e.pc);
            end
         end
      end
   end

   initial begin
      rst       = 1'b1;
      start     = 1'b0;
      ir        = 32'h0;
      mem_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_idle("reset");
      rst = 1'b0;
      @(posedge clk);
      #1;

      // LDM {R0,R2,R15} with write-back
      launch(16'h8005, 1'b1, 1'b1, 3);
      wait_done("ldm_8005", 4);

      // STM {R4..R7}, no write-back, restarted the cycle after DONE
      launch(16'h00F0, 1'b0, 1'b0, 4);
      wait_done("stm_00f0", 4);

      // backpressure on beat 0
      mem_ready = 1'b0;
      launch(16'h0003, 1'b0, 1'b0, 2);
      repeat (3) @(posedge clk);
      #1;
      mem_ready = 1'b1;
      wait_done("backpressure", 2);

      // empty list with W set
      launch(16'h0000, 1'b1, 1'b1, 0);
      wait_done("empty", 0);

      // reset during beat 2 of a full list
      launch(16'hFFFF, 1'b0, 1'b0, 16);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      sb.delete();
      check_idle("abort");
      @(posedge clk);
      #1;
      check_idle("abort_hold");
      launch(16'h0001, 1'b1, 1'b0, 1);
      wait_done("after_abort", 1);

      // full list with a second start mid-transfer
      launch(16'hFFFF, 1'b1, 1'b1, 16);
      repeat (3) @(posedge clk);
      #1;
      ir    = 32'h0000_0001;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      chk("restart_reg_count", reg_count, 16);
      wait_done("full_ffff", 13);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, %0d failed so far", n_fail);
      $fatal(1, "watchdog");
   end

endmodule
